// File: rtl/lif_timestep_scheduler.sv
// Time-multiplexed binary LIF update engine: one start runs one timestep over all neurons.
// Optional refractory counters are enabled by defining LIF_REFRACTORY_EN.
module lif_timestep_scheduler #(
  parameter int N_NEURONS    = 8,
  parameter int POT_W        = 4,
  parameter int THRESHOLD    = 5,
  parameter int LEAK         = 1,
  parameter int REFRAC_STEPS = 2,
  localparam int IDX_W       = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_NEURONS-1:0] in_vec,
  output logic                 busy,
  output logic                 done,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic [IDX_W-1:0]     neuron_idx
);

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t               state_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic [N_NEURONS-1:0] spike_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [N_NEURONS-1:0] in_lat_reg;
  logic [N_NEURONS-1:0] acc_reg;
  logic [POT_W-1:0]     pot_reg [N_NEURONS];

`ifdef LIF_REFRACTORY_EN
  localparam int RW = $clog2(REFRAC_STEPS + 1);
  logic [RW-1:0]        refrac_reg [N_NEURONS];
`endif

  logic [POT_W-1:0]     pot_cur;
  logic [POT_W-1:0]     pot_upd;
  logic                 in_bit;
  logic                 fire;
  logic                 blocked;
  logic                 fire_eff;
  logic [N_NEURONS-1:0] acc_next;

  always_comb begin
    pot_cur = pot_reg[idx_reg];
    in_bit  = in_lat_reg[idx_reg];
    pot_upd = '0;
    if (in_bit) begin
      pot_upd = (pot_cur == {POT_W{1'b1}}) ? pot_cur : pot_cur + 1'b1;
    end else if (int'(pot_cur) >= LEAK) begin
      pot_upd = POT_W'(int'(pot_cur) - LEAK);
    end
    fire = (int'(pot_upd) >= THRESHOLD);
`ifdef LIF_REFRACTORY_EN
    blocked = (refrac_reg[idx_reg] != '0);
`else
    blocked = 1'b0;
`endif
    fire_eff = fire & ~blocked;
    acc_next = acc_reg;
    acc_next[idx_reg] = acc_reg[idx_reg] | fire_eff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      spike_reg  <= '0;
      idx_reg    <= '0;
      in_lat_reg <= '0;
      acc_reg    <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        pot_reg[i] <= '0;
`ifdef LIF_REFRACTORY_EN
        refrac_reg[i] <= '0;
`endif
      end
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            in_lat_reg <= in_vec;
            acc_reg    <= '0;
            idx_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= UPDATE;
          end
        end
        UPDATE: begin
          // A firing or refractory neuron is left at rest potential.
          pot_reg[idx_reg] <= (fire | blocked) ? '0 : pot_upd;
`ifdef LIF_REFRACTORY_EN
          if (blocked)
            refrac_reg[idx_reg] <= refrac_reg[idx_reg] - 1'b1;
          else if (fire)
            refrac_reg[idx_reg] <= RW'(REFRAC_STEPS);
`endif
          acc_reg <= acc_next;
          if (idx_reg == IDX_W'(N_NEURONS - 1)) begin
            idx_reg   <= '0;
            done_reg  <= 1'b1;
            spike_reg <= acc_next;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign spike_vec  = spike_reg;
  assign neuron_idx = idx_reg;

endmodule
